// File: rtl/trigger_counter_pkg.sv
`default_nettype none
// ============================================================================
// trigger_counter_pkg : shared state type and default lengths
// Rev 1.0
// ============================================================================
package trigger_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int COUNT0_DEF = 5;
  localparam int COUNT1_DEF = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/down_up_cnt.sv
`default_nettype none
// ============================================================================
// down_up_cnt : loadable up/down counter with clear, enable and terminal compare
// Rev 1.0
// ============================================================================
module down_up_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [W-1:0] term_val_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear beats load beats count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = up_i ? (cnt_q + W'(1)) : (cnt_q - W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == term_val_i);

endmodule
`default_nettype wire

// File: rtl/trigger_counter.sv
`default_nettype none
// ============================================================================
// trigger_counter : single-shot trigger-started counter, one-cycle cf pulse
// Rev 1.0
// ============================================================================
module trigger_counter
  import trigger_counter_pkg::*;
#(
  parameter int COUNT0 = COUNT0_DEF,
  parameter int COUNT1 = COUNT1_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tr,
  input  logic mode,
  output logic cf
);

  localparam int              C_CNT_W = $clog2(max_int(COUNT0, COUNT1) + 1);
  localparam logic [C_CNT_W-1:0] C_LEN0 = C_CNT_W'(COUNT0);
  localparam logic [C_CNT_W-1:0] C_LEN1 = C_CNT_W'(COUNT1);
  localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

  generate
    if (COUNT0 < 2) begin : g_count0_invalid
      $error("trigger_counter: COUNT0 must be >= 2");
    end
    if (COUNT1 < 2) begin : g_count1_invalid
      $error("trigger_counter: COUNT1 must be >= 2");
    end
  endgenerate

  state_e               state_q, state_d;
  logic [C_CNT_W-1:0]   lim_q, lim_d;
  logic                 cf_q, cf_d;

  logic                 w_cnt_clr;
  logic                 w_cnt_load;
  logic                 w_cnt_en;
  logic                 w_cnt_term;
  logic [C_CNT_W-1:0]   w_term_val;

  // Counter starts at 1 on the accepting edge, so lim-1 is the last COUNT value.
  assign w_term_val = lim_q - C_ONE;

  down_up_cnt #(
    .W (C_CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (w_cnt_clr),
    .load_i     (w_cnt_load),
    .load_val_i (C_ONE),
    .en_i       (w_cnt_en),
    .up_i       (1'b1),
    .term_val_i (w_term_val),
    .term_o     (w_cnt_term)
  );

  always_comb begin
    state_d    = state_q;
    lim_d      = lim_q;
    w_cnt_clr  = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tr) begin
          w_cnt_load = 1'b1;
          lim_d      = mode ? C_LEN1 : C_LEN0;
          state_d    = ST_COUNT;
        end else begin
          w_cnt_clr  = 1'b1;
        end
      end
      ST_COUNT: begin
        if (w_cnt_term) begin
          state_d  = ST_DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        w_cnt_clr = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        w_cnt_clr = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // cf follows DONE by one register so it rises N edges after the trigger.
  assign cf_d = (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lim_q   <= C_LEN0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      cf_q    <= cf_d;
    end
  end

  assign cf = cf_q;

endmodule
`default_nettype wire

// File: tb/tb_trigger_counter.sv
`default_nettype none
// ============================================================================
// tb_trigger_counter : directed + random stimulus against a timing-level model
// Rev 1.0
// ============================================================================
module tb_trigger_counter;

  localparam int COUNT0 = 5;
  localparam int COUNT1 = 10;

  logic clk;
  logic reset;
  logic tr;
  logic mode;
  logic cf;

  int checks;
  int errors;

  // Model state: edge index, edge on which cf must be high, earliest accept edge.
  int cyc;
  int cf_at;
  int next_free;
  logic exp_cf;
  logic model_valid;

  int hits[$];

  trigger_counter #(
    .COUNT0 (COUNT0),
    .COUNT1 (COUNT1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tr    (tr),
    .mode  (mode),
    .cf    (cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A trigger accepted at edge t makes cf high after edge t+N only, and blocks
  // further triggers until edge t+N+1.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      exp_cf    = 1'b0;
      cf_at     = -1;
      next_free = cyc + 1;
    end else begin
      exp_cf = (cyc == cf_at);
      if (tr && (cyc >= next_free)) begin
        cf_at     = cyc + (mode ? COUNT1 : COUNT0);
        next_free = cf_at + 1;
      end
    end
    model_valid = 1'b1;
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (model_valid) begin
        checks = checks + 1;
        if (cf !== exp_cf) begin
          errors = errors + 1;
          $display("FAIL cf_cycle edge=%0d actual=%b required=%b", cyc, cf, exp_cf);
        end
        if (cf === 1'b1) hits.push_back(cyc);
      end
    end
  endtask

  task automatic check_int(input string name, input int actual, input int required);
    checks = checks + 1;
    if (actual != required) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Drives inputs for the next rising edge and returns that edge's index.
  task automatic drive(input logic r, input logic t, input logic m, output int edge_idx);
    @(negedge clk);
    reset = r;
    tr    = t;
    mode  = m;
    edge_idx = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, e);
  endtask

  initial begin
    int t0;
    int e;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    cf_at       = -1;
    next_free   = 0;
    exp_cf      = 1'b0;
    model_valid = 1'b0;
    reset       = 1'b0;
    tr          = 1'b1;
    mode        = 1'b0;

    fork
      compare_loop();
    join_none

    // Reset held with tr high: no count may start.
    drive(1'b0, 1'b1, 1'b1, e);
    drive(1'b0, 1'b1, 1'b0, e);
    idle(12);
    check_int("reset_no_cf", hits.size(), 0);

    // Mode 0 single pulse.
    hits.delete();
    drive(1'b1, 1'b1, 1'b0, t0);
    idle(12);
    check_int("mode0_count", hits.size(), 1);
    if (hits.size() > 0) check_int("mode0_edge", hits[0] - t0, 5);

    // Mode 1 latched at the trigger; later mode changes ignored.
    hits.delete();
    drive(1'b1, 1'b1, 1'b1, t0);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1'b0, e);
    check_int("mode1_count", hits.size(), 1);
    if (hits.size() > 0) check_int("mode1_edge", hits[0] - t0, 10);

    // Retrigger during COUNT is ignored.
    hits.delete();
    drive(1'b1, 1'b1, 1'b0, t0);
    idle(2);
    drive(1'b1, 1'b1, 1'b0, e);
    idle(12);
    check_int("retrig_count", hits.size(), 1);
    if (hits.size() > 0) check_int("retrig_edge", hits[0] - t0, 5);

    // Reset mid-count aborts; a later trigger counts normally.
    hits.delete();
    drive(1'b1, 1'b1, 1'b1, t0);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, e);
    check_int("abort_reset_edge", e - t0, 4);
    idle(14);
    check_int("abort_no_cf", hits.size(), 0);
    drive(1'b1, 1'b1, 1'b0, t0);
    idle(10);
    check_int("after_abort_count", hits.size(), 1);
    if (hits.size() > 0) check_int("after_abort_edge", hits[0] - t0, 5);

    // tr held high: restart every N+1 edges.
    hits.delete();
    drive(1'b1, 1'b1, 1'b0, t0);
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, 1'b0, e);
    idle(4);
    check_int("b2b_count", hits.size(), 3);
    if (hits.size() == 3) begin
      check_int("b2b_edge0", hits[0] - t0, 5);
      check_int("b2b_edge1", hits[1] - t0, 11);
      check_int("b2b_edge2", hits[2] - t0, 17);
    end

    // Random traffic, checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)), e);
    end
    idle(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
